// File: rtl/data_mem_responder.sv
// Single-port data memory responder with a valid/ready request and response
// handshake. A request is accepted in IDLE, optionally delayed WAIT_CYCLES
// cycles, then the access is performed and the response held until consumed.
// Optional feature: define DATA_MEM_MISALIGN_TRAP_EN to report misaligned half
// and word accesses as errors instead of silently aligning them.
module data_mem_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_error,
  output logic        busy
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);
  localparam int AW    = IDX_W + 2;

`ifdef DATA_MEM_MISALIGN_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  // Reserved size always fails; misalignment fails only when trapping is built in.
  function automatic logic access_error(input logic [1:0] size, input logic [1:0] off);
    logic mis;
    mis = ((size == 2'b01) && off[0]) || ((size == 2'b10) && (off != 2'b00));
    return (size == 2'b11) || (TRAP_EN && mis);
  endfunction

  // Select the addressed lane and sign- or zero-extend it to 32 bits.
  function automatic logic [31:0] load_extend(input logic [31:0] word, input logic [1:0] size,
                                              input logic [1:0] off, input logic uns);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    case (off)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      default: b = word[31:24];
    endcase
    h = off[1] ? word[31:16] : word[15:0];
    case (size)
      2'b00:   r = uns ? {24'd0, b} : {{24{b[7]}}, b};
      2'b01:   r = uns ? {16'd0, h} : {{16{h[15]}}, h};
      default: r = word;
    endcase
    return r;
  endfunction

  // Merge right-aligned store data into the addressed lanes of the old word.
  function automatic logic [31:0] merge_store(input logic [31:0] old, input logic [31:0] wd,
                                              input logic [1:0] size, input logic [1:0] off);
    logic [31:0] r;
    r = old;
    case (size)
      2'b00: begin
        case (off)
          2'd0:    r[7:0]   = wd[7:0];
          2'd1:    r[15:8]  = wd[7:0];
          2'd2:    r[23:16] = wd[7:0];
          default: r[31:24] = wd[7:0];
        endcase
      end
      2'b01: begin
        if (off[1]) r[31:16] = wd[15:0];
        else        r[15:0]  = wd[15:0];
      end
      default: r = wd;
    endcase
    return r;
  endfunction

  state_t          state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic            enter_resp;
  logic            accept;

  logic            write_q;
  logic [1:0]      size_q;
  logic            uns_q;
  logic [AW-1:0]   addr_q;
  logic [31:0]     wdata_q;

  logic [31:0]     rdata_q;
  logic            error_q;

  logic [31:0]     mem_q [DEPTH_WORDS];

  logic            op_write;
  logic [1:0]      op_size;
  logic            op_uns;
  logic [AW-1:0]   op_addr;
  logic [31:0]     op_wdata;
  logic [IDX_W-1:0] op_idx;
  logic [1:0]      op_off;
  logic [31:0]     cur_word;
  logic            op_err;
  logic [31:0]     ld_data;
  logic [31:0]     st_word;
  logic            do_write;

  logic            unused_addr_hi;
  assign unused_addr_hi = ^req_addr[31:AW];

  assign req_ready = (state_q == IDLE) && !reset;
  assign accept    = req_valid && req_ready;
  assign rsp_valid = (state_q == RESP);
  assign busy      = (state_q != IDLE);
  assign rsp_rdata = rdata_q;
  assign rsp_error = error_q;

  // Next-state logic: count down in WAIT, leave RESP on the response handshake.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    enter_resp = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (WAIT_CYCLES == 0) begin
            state_d    = RESP;
            enter_resp = 1'b1;
          end else begin
            state_d = WAIT;
            cnt_d   = 4'(WAIT_CYCLES);
          end
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) begin
          state_d    = RESP;
          enter_resp = 1'b1;
          cnt_d      = 4'd0;
        end
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Access operands: live request when entering RESP straight from IDLE, latched copy otherwise.
  always_comb begin
    if (state_q == IDLE) begin
      op_write = req_write;
      op_size  = req_size;
      op_uns   = req_unsigned;
      op_addr  = req_addr[AW-1:0];
      op_wdata = req_wdata;
    end else begin
      op_write = write_q;
      op_size  = size_q;
      op_uns   = uns_q;
      op_addr  = addr_q;
      op_wdata = wdata_q;
    end
  end

  assign op_idx   = op_addr[AW-1:2];
  assign op_off   = op_addr[1:0];
  assign cur_word = mem_q[op_idx];
  assign op_err   = access_error(op_size, op_off);
  assign ld_data  = (op_err || op_write) ? 32'd0 : load_extend(cur_word, op_size, op_off, op_uns);
  assign st_word  = merge_store(cur_word, op_wdata, op_size, op_off);
  assign do_write = enter_resp && op_write && !op_err && !reset;

  // Control and response registers; reset abandons any transaction in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      rdata_q <= 32'd0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (enter_resp) begin
        rdata_q <= ld_data;
        error_q <= op_err;
      end
    end
  end

  // Request capture, only on an accepted handshake.
  always_ff @(posedge clk) begin
    if (accept) begin
      write_q <= req_write;
      size_q  <= req_size;
      uns_q   <= req_unsigned;
      addr_q  <= req_addr[AW-1:0];
      wdata_q <= req_wdata;
    end
  end

  // Storage update on the edge that enters RESP; contents survive reset.
  always_ff @(posedge clk) begin
    if (do_write) mem_q[op_idx] <= st_word;
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Table-driven bench for data_mem_responder with a response scoreboard,
// plus hand-written backpressure and mid-transaction reset sequences.
module tb_data_mem_responder;

  localparam int DEPTH = 256;
  localparam int WC    = 1;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_error;
  logic        busy;

  always #5 clk = ~clk;

  data_mem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(WC)) dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_write    (req_write),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_rdata    (rsp_rdata),
    .rsp_error    (rsp_error),
    .busy         (busy)
  );

  typedef struct {
    logic        w;
    logic [1:0]  sz;
    logic        u;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] exp_d;
    logic        exp_e;
    string       name;
  } vec_t;

  typedef struct {
    logic [31:0] d;
    logic        e;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[$];
  int   n_vec  = 0;
  int   n_fail = 0;

`ifdef DATA_MEM_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  function automatic vec_t mk(input logic w, input logic [1:0] sz, input logic u,
                              input logic [31:0] addr, input logic [31:0] wd,
                              input logic [31:0] exp_d, input logic exp_e, input string name);
    vec_t v;
    v.w = w; v.sz = sz; v.u = u; v.addr = addr; v.wd = wd;
    v.exp_d = exp_d; v.exp_e = exp_e; v.name = name;
    return v;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", nm, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    req_write    = v.w;
    req_size     = v.sz;
    req_unsigned = v.u;
    req_addr     = v.addr;
    req_wdata    = v.wd;
    req_valid    = 1'b1;
  endtask

  task automatic pop_check(input string nm);
    exp_t e;
    if (sb.size() == 0) begin
      check({nm, " scoreboard empty"}, 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      check({nm, " rdata"}, rsp_rdata, e.d);
      check({nm, " error"}, {31'd0, rsp_error}, {31'd0, e.e});
    end
  endtask

  // Full transaction: accept, measure latency, compare, handshake.
  task automatic transact(input vec_t v);
    exp_t e;
    int   t;
    int   lat;
    e.d = v.exp_d;
    e.e = v.exp_e;
    sb.push_back(e);
    drive(v);
    t = 0;
    while (!req_ready && t < 20) begin
      @(posedge clk); #1; t++;
    end
    check({v.name, " ready"}, {31'd0, req_ready}, 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 40) begin
      @(posedge clk); #1; lat++;
    end
    check({v.name, " latency"}, 32'(lat), 32'(WC + 1));
    pop_check(v.name);
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    check({v.name, " valid drop"}, {31'd0, rsp_valid}, 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int t;
    logic [31:0] held;
    reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00;
    req_unsigned = 1'b0; req_addr = 32'd0; req_wdata = 32'd0; rsp_ready = 1'b0;

    vecs.push_back(mk(1, 2'b10, 0, 32'h10,  32'hDEADBEEF, 32'h0, 0, "st w deadbeef"));
    vecs.push_back(mk(0, 2'b10, 0, 32'h10,  32'h0,        32'hDEADBEEF, 0, "ld w 10"));
    vecs.push_back(mk(1, 2'b10, 0, 32'h10,  32'h0,        32'h0, 0, "st w zero"));
    vecs.push_back(mk(1, 2'b00, 0, 32'h13,  32'hAAAAAA80, 32'h0, 0, "st b 13"));
    vecs.push_back(mk(0, 2'b00, 0, 32'h13,  32'h0,        32'hFFFFFF80, 0, "ld b s 13"));
    vecs.push_back(mk(0, 2'b00, 1, 32'h13,  32'h0,        32'h00000080, 0, "ld b u 13"));
    vecs.push_back(mk(0, 2'b10, 0, 32'h10,  32'h0,        32'h80000000, 0, "ld w after b"));
    vecs.push_back(mk(1, 2'b01, 0, 32'h12,  32'h1234F00D, 32'h0, 0, "st h 12"));
    vecs.push_back(mk(0, 2'b10, 0, 32'h10,  32'h0,        32'hF00D0000, 0, "ld w after h"));
    vecs.push_back(mk(0, 2'b01, 0, 32'h12,  32'h0,        32'hFFFFF00D, 0, "ld h s 12"));
    vecs.push_back(mk(0, 2'b01, 1, 32'h12,  32'h0,        32'h0000F00D, 0, "ld h u 12"));
    vecs.push_back(mk(0, 2'b00, 0, 32'h12,  32'h0,        32'h0000000D, 0, "ld b s 12"));
    vecs.push_back(mk(1, 2'b10, 0, 32'h400, 32'h11223344, 32'h0, 0, "st w 400"));
    vecs.push_back(mk(0, 2'b10, 0, 32'h0,   32'h0,        32'h11223344, 0, "ld w wrap 0"));
    vecs.push_back(mk(0, 2'b00, 1, 32'h401, 32'h0,        32'h00000033, 0, "ld b wrap 401"));
    vecs.push_back(mk(1, 2'b10, 0, 32'h10,  32'hCAFEBABE, 32'h0, 0, "st w cafebabe"));
    vecs.push_back(mk(0, 2'b01, 1, 32'h11,  32'h0,
                      TRAP ? 32'h0 : 32'h0000BABE, TRAP, "ld h misalign 11"));
    vecs.push_back(mk(0, 2'b11, 0, 32'h10,  32'h0,        32'h0, 1, "ld size11"));
    vecs.push_back(mk(1, 2'b11, 0, 32'h10,  32'h0,        32'h0, 1, "st size11"));
    vecs.push_back(mk(0, 2'b10, 0, 32'h10,  32'h0,        32'hCAFEBABE, 0, "ld w after bad st"));
    vecs.push_back(mk(0, 2'b10, 0, 32'h12,  32'h0,
                      TRAP ? 32'h0 : 32'hCAFEBABE, TRAP, "ld w misalign 12"));

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst req_ready", {31'd0, req_ready}, 32'd0);
    check("rst rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("rst busy",      {31'd0, busy},      32'd0);
    check("rst rsp_rdata", rsp_rdata,          32'd0);
    check("rst rsp_error", {31'd0, rsp_error}, 32'd0);
    reset = 1'b0;
    #1;
    check("post rst ready", {31'd0, req_ready}, 32'd1);

    for (int i = 0; i < vecs.size(); i++) transact(vecs[i]);

    // Backpressure: response held for 5 cycles while another request waits
    transact(mk(1, 2'b10, 0, 32'h10, 32'h0BADF00D, 32'h0, 0, "bp store"));
    begin
      exp_t e;
      e.d = 32'h0BADF00D; e.e = 1'b0;
      sb.push_back(e);
    end
    drive(mk(0, 2'b10, 0, 32'h10, 32'h0, 32'h0, 0, "bp load"));
    @(posedge clk); #1;
    req_write = 1'b1; req_wdata = 32'hFFFFFFFF;
    t = 0;
    while (!rsp_valid && t < 40) begin
      check("bp ready while busy", {31'd0, req_ready}, 32'd0);
      @(posedge clk); #1; t++;
    end
    check("bp valid seen", {31'd0, rsp_valid}, 32'd1);
    pop_check("bp load");
    held = rsp_rdata;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("bp valid hold", {31'd0, rsp_valid}, 32'd1);
      check("bp rdata hold", rsp_rdata, held);
      check("bp req_ready",  {31'd0, req_ready}, 32'd0);
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0; req_valid = 1'b0;
    check("bp valid drop", {31'd0, rsp_valid}, 32'd0);
    check("bp busy drop",  {31'd0, busy},      32'd0);
    transact(mk(0, 2'b10, 0, 32'h10, 32'h0, 32'h0BADF00D, 0, "bp not latched"));

    // Reset while in WAIT abandons a store
    transact(mk(1, 2'b10, 0, 32'h20, 32'hA5A5A5A5, 32'h0, 0, "pre store 20"));
    drive(mk(1, 2'b10, 0, 32'h20, 32'h12345678, 32'h0, 0, "abandoned st"));
    @(posedge clk); #1;
    req_valid = 1'b0;
    check("wait busy", {31'd0, busy}, 32'd1);
    reset = 1'b1;
    @(posedge clk); #1;
    check("rst wait valid", {31'd0, rsp_valid}, 32'd0);
    check("rst wait busy",  {31'd0, busy},      32'd0);
    check("rst wait ready", {31'd0, req_ready}, 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;
    transact(mk(0, 2'b10, 0, 32'h20, 32'h0, 32'hA5A5A5A5, 0, "ld 20 after rst"));

    // Reset while in RESP drops the response
    drive(mk(0, 2'b10, 0, 32'h20, 32'h0, 32'h0, 0, "resp rst load"));
    @(posedge clk); #1;
    req_valid = 1'b0;
    t = 0;
    while (!rsp_valid && t < 40) begin
      @(posedge clk); #1; t++;
    end
    check("resp rst valid seen", {31'd0, rsp_valid}, 32'd1);
    reset = 1'b1;
    @(posedge clk); #1;
    check("resp rst valid", {31'd0, rsp_valid}, 32'd0);
    check("resp rst rdata", rsp_rdata,          32'd0);
    reset = 1'b0;
    @(posedge clk); #1;
    transact(mk(0, 2'b10, 0, 32'h20, 32'h0, 32'hA5A5A5A5, 0, "ld 20 after resp rst"));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/data_mem_responder.md
DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 256: number of 32-bit storage words; power of two, at least 4.
REQ-002 SHALL have parameter WAIT_CYCLES, default 1: extra cycles between request acceptance and response; range 0..15.
REQ-003 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port req_valid, input, 1: the core presents a load/store request.
REQ-006 SHALL have port req_ready, output, 1: the block accepts a request this cycle.
REQ-007 SHALL have port req_write, input, 1: 1 = store, 0 = load.
REQ-008 SHALL have port req_size, input, 2: 00 = byte, 01 = half, 10 = word, 11 = reserved.
REQ-009 SHALL have port req_unsigned, input, 1: load zero-extends when 1 and sign-extends when 0.
REQ-010 SHALL have port req_addr, input, 32: byte address.
REQ-011 SHALL have port req_wdata, input, 32: store data, right-aligned (byte in [7:0], half in [15:0]).
REQ-012 SHALL have port rsp_valid, output, 1: a response is presented.
REQ-013 SHALL have port rsp_ready, input, 1: the core consumes the response.
REQ-014 SHALL have port rsp_rdata, output, 32: extended load data; 0 for stores and errors.
REQ-015 SHALL have port rsp_error, output, 1: the request was rejected.
REQ-016 SHALL have port busy, output, 1: high whenever the state is not IDLE.

Function
REQ-017 SHALL implement FSM states IDLE, WAIT and RESP.
REQ-018 SHALL drive req_ready = 1 only in IDLE with reset low.
REQ-019 SHALL accept a request on a rising edge when req_valid and req_ready are both high, registering write, size, unsigned, addr and wdata.
REQ-020 After acceptance, SHALL go IDLE->WAIT with a wait counter loaded to WAIT_CYCLES, or IDLE->RESP directly when WAIT_CYCLES = 0.
REQ-021 In WAIT, SHALL decrement the counter each cycle and go to RESP on the edge after the counter reaches 1.
REQ-022 SHALL perform the storage access, and register rsp_rdata and rsp_error, on the edge that enters RESP.
REQ-023 SHALL assert rsp_valid WAIT_CYCLES+1 cycles after the acceptance edge.
REQ-024 In RESP, SHALL hold rsp_valid, rsp_rdata and rsp_error stable until rsp_ready is high.
REQ-025 In RESP, SHALL return to IDLE on the edge where rsp_ready is high; rsp_valid drops the same edge.
REQ-026 SHALL allow a new request to be accepted no earlier than the cycle after the response handshake.
REQ-027 SHALL compute the word index as req_addr[log2(DEPTH_WORDS)+1:2], silently wrapping addresses beyond the depth.
REQ-028 SHALL select the byte lane by addr[1:0] and the half lane by addr[1].
REQ-029 SHALL write only the addressed lanes on stores and leave all other bytes unchanged.
REQ-030 SHALL extend loaded byte/half data per req_unsigned to 32 bits.
REQ-031 SHALL treat req_size = 11 as an error: no write, rsp_rdata = 0, rsp_error = 1.
REQ-032 SHALL ignore req_valid while busy and SHALL NOT latch any input while busy.

Reset
REQ-033 While reset is high at an edge, SHALL force: state IDLE, wait counter 0, rsp_valid 0, rsp_rdata 0, rsp_error 0, busy 0.
REQ-034 SHALL hold req_ready at 0 while reset is high.
REQ-035 On reset mid-transaction (in WAIT, or in RESP), SHALL abandon the transaction; a store not yet reaching RESP is not performed.
REQ-036 SHALL NOT clear storage contents on reset.

Configuration
REQ-037 With macro DATA_MEM_MISALIGN_TRAP_EN defined, SHALL flag misaligned requests as errors: half with addr[0] = 1, or word with addr[1:0] != 0; no write, rsp_rdata = 0, rsp_error = 1.
REQ-038 Without DATA_MEM_MISALIGN_TRAP_EN, SHALL ignore the offending low address bits (half uses addr[1] only, word uses addr[1:0] = 00) and SHALL NOT raise rsp_error for alignment.

Verification
REQ-039 WAIT_CYCLES = 1; store word 0xDEADBEEF @0x10, then load word @0x10 -> each rsp_valid 2 cycles after acceptance; load rsp_rdata = 0xDEADBEEF, rsp_error = 0.
REQ-040 Store byte 0x80 @0x13 over 0x00000000, then load byte signed and unsigned @0x13 -> rsp_rdata = 0xFFFFFF80 and 0x00000080; load word @0x10 -> 0x80000000.
REQ-041 Hold rsp_ready low for 5 cycles in RESP -> rsp_valid and rsp_rdata stable; req_ready stays 0 with req_valid high throughout; completes on the rsp_ready edge.
REQ-042 Load half @0x11 -> with DATA_MEM_MISALIGN_TRAP_EN: rsp_error = 1, rsp_rdata = 0; without: returns the half @0x10, rsp_error = 0; req_size = 11 -> rsp_error = 1 in both builds.
REQ-043 Assert reset in WAIT during a store of 0x12345678 @0x20 -> rsp_valid = 0 next cycle, state IDLE; later load @0x20 returns the prior contents.
REQ-044 DEPTH_WORDS = 256; store word @0x400 -> a load word @0x000 returns the same data (wrap-around).
